// File: rtl/param_datapath.sv
// Parameterised accumulator datapath: internal bus, AR/PC/DR/IR/AC,
// a small general register file, a single-cycle ALU and an iterative
// shift-add multiplier that holds AC/flags while it runs.
//
// Bus handshake: there is no valid/ready pair here. The only flow-control
// signal is busy; while it is high alu_start and ld[3] are ignored, all
// other loads and the PC keep working, and the first cycle busy is low
// accepts a new ALU issue.
module param_datapath #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int NREG   = 4,
   localparam int RS_W  = $clog2(NREG)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] dram_in,
   input  logic [DATA_W-1:0] iram_in,
   input  logic [3:0]        bus_sel,
   input  logic [5:0]        ld,
   input  logic [RS_W-1:0]   reg_sel,
   input  logic              pc_inc,
   input  logic [2:0]        alu_op,
   input  logic              alu_start,
   output logic [DATA_W-1:0] bus_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic [ADDR_W-1:0] pc_addr,
   output logic [DATA_W-1:0] ir_out,
   output logic [DATA_W-1:0] ac_out,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } mul_state_e;

   mul_state_e state_q, state_d;

   logic [DATA_W-1:0] ar_q, pc_q, dr_q, ir_q, ac_q;
   logic [DATA_W-1:0] r_q [NREG];
   logic              z_q, n_q, c_q;

   // Multiplier working set: multiplicand, running high half, and the
   // low half which starts as the multiplier and fills with product bits.
   logic [DATA_W-1:0] mcand_q, hi_q, lo_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              issue_single, issue_mul, mul_done;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic [DATA_W:0]   add_w, sub_w, mul_sum;
   logic [DATA_W-1:0] mul_hi_nxt, mul_lo_nxt;

   // Internal bus source mux; register sources show pre-edge values.
   always_comb begin
      bus_out = '0;
      case (bus_sel)
         4'd1:    bus_out = ar_q;
         4'd2:    bus_out = pc_q;
         4'd3:    bus_out = ir_q;
         4'd4:    bus_out = dr_q;
         4'd5:    bus_out = r_q[reg_sel];
         4'd6:    bus_out = ac_q;
         4'd7:    bus_out = dram_in;
         4'd8:    bus_out = iram_in;
         default: bus_out = '0;
      endcase
   end

   // Single-cycle ALU result and carry; PASS keeps the old carry.
   always_comb begin
      add_w   = {1'b0, ac_q} + {1'b0, bus_out};
      sub_w   = {1'b0, ac_q} - {1'b0, bus_out};
      alu_res = bus_out;
      alu_c   = c_q;
      case (alu_op)
         OP_PASS: begin alu_res = bus_out;              alu_c = c_q;            end
         OP_ADD:  begin alu_res = add_w[DATA_W-1:0];    alu_c = add_w[DATA_W];  end
         OP_SUB:  begin alu_res = sub_w[DATA_W-1:0];    alu_c = sub_w[DATA_W];  end
         OP_AND:  begin alu_res = ac_q & bus_out;       alu_c = 1'b0;           end
         OP_OR:   begin alu_res = ac_q | bus_out;       alu_c = 1'b0;           end
         OP_XOR:  begin alu_res = ac_q ^ bus_out;       alu_c = 1'b0;           end
         OP_SHL:  begin alu_res = {ac_q[DATA_W-2:0], 1'b0}; alu_c = ac_q[DATA_W-1]; end
         default: begin alu_res = bus_out;              alu_c = c_q;            end
      endcase
   end

   // One shift-add step: conditionally add multiplicand into the high
   // half, then shift {carry, hi, lo} right by one.
   always_comb begin
      mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
      mul_hi_nxt = mul_sum[DATA_W:1];
      mul_lo_nxt = {mul_sum[0], lo_q[DATA_W-1:1]};
   end

   // Multiplier control: next state and issue/complete strobes.
   always_comb begin
      state_d      = state_q;
      issue_single = 1'b0;
      issue_mul    = 1'b0;
      mul_done     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (alu_start) begin
               if (alu_op == OP_MUL) begin
                  issue_mul = 1'b1;
                  state_d   = ST_MUL;
               end else begin
                  issue_single = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (cnt_q == LAST_STEP) begin
               mul_done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Multiplier state register and working registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (issue_mul) begin
            mcand_q <= ac_q;
            hi_q    <= '0;
            lo_q    <= bus_out;
            cnt_q   <= '0;
         end else if (state_q == ST_MUL) begin
            hi_q    <= mul_hi_nxt;
            lo_q    <= mul_lo_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Bus-loaded registers and program counter; unaffected by busy.
   always_ff @(posedge clock) begin
      if (reset) begin
         ar_q <= '0;
         dr_q <= '0;
         ir_q <= '0;
         pc_q <= '0;
         for (int i = 0; i < NREG; i++) r_q[i] <= '0;
      end else begin
         if (ld[0]) r_q[reg_sel] <= bus_out;
         if (ld[1]) ar_q <= bus_out;
         if (ld[2]) dr_q <= bus_out;
         if (ld[5]) ir_q <= bus_out;
         if (ld[4])       pc_q <= bus_out;
         else if (pc_inc) pc_q <= pc_q + DATA_W'(1);
      end
   end

   // Accumulator and flags: MUL completion, then ALU issue, then plain load.
   always_ff @(posedge clock) begin
      if (reset) begin
         ac_q <= '0;
         z_q  <= 1'b0;
         n_q  <= 1'b0;
         c_q  <= 1'b0;
      end else if (mul_done) begin
         ac_q <= mul_lo_nxt;
         z_q  <= (mul_lo_nxt == '0);
         n_q  <= mul_lo_nxt[DATA_W-1];
         c_q  <= (mul_hi_nxt != '0);
      end else if (issue_single) begin
         ac_q <= alu_res;
         z_q  <= (alu_res == '0);
         n_q  <= alu_res[DATA_W-1];
         c_q  <= alu_c;
      end else if (ld[3] && state_q == ST_IDLE && !alu_start) begin
         ac_q <= bus_out;
      end
   end

   assign addr_out = ar_q[ADDR_W-1:0];
   assign pc_addr  = pc_q[ADDR_W-1:0];
   assign ir_out   = ir_q;
   assign ac_out   = ac_q;
   assign flag_z   = z_q;
   assign flag_n   = n_q;
   assign flag_c   = c_q;
   assign busy     = (state_q == ST_MUL);

endmodule

// File: tb/tb_param_datapath.sv
// Testbench for param_datapath at default parameters. A driver applies
// one cycle of inputs at a time, advances a behavioural model and pushes
// the expected post-edge outputs; a monitor pops and compares after each
// rising edge.
module tb_param_datapath;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] ar;
      logic [W-1:0] ir;
      logic [W-1:0] ac;
      logic         z;
      logic         n;
      logic         c;
      logic         busy;
   } exp_t;

   logic         clock, reset;
   logic [W-1:0] dram_in, iram_in;
   logic [3:0]   bus_sel;
   logic [5:0]   ld;
   logic [1:0]   reg_sel;
   logic         pc_inc;
   logic [2:0]   alu_op;
   logic         alu_start;
   logic [W-1:0] bus_out, addr_out, pc_addr, ir_out, ac_out;
   logic         flag_z, flag_n, flag_c, busy;

   param_datapath dut (
      .clock(clock), .reset(reset), .dram_in(dram_in), .iram_in(iram_in),
      .bus_sel(bus_sel), .ld(ld), .reg_sel(reg_sel), .pc_inc(pc_inc),
      .alu_op(alu_op), .alu_start(alu_start), .bus_out(bus_out),
      .addr_out(addr_out), .pc_addr(pc_addr), .ir_out(ir_out),
      .ac_out(ac_out), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
      .busy(busy)
   );

   // ---------------- clock ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- scoreboard state ----------------
   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0]   m_ar, m_pc, m_dr, m_ir, m_ac;
   logic [W-1:0]   m_r [4];
   logic           m_z, m_n, m_c;
   int             m_mul_left;
   logic [2*W-1:0] m_mul_prod;

   function automatic logic [W-1:0] model_bus(input logic [3:0] bs, input logic [1:0] rs,
                                              input logic [W-1:0] dr_in, input logic [W-1:0] ir_in);
      case (bs)
         4'd1: return m_ar;
         4'd2: return m_pc;
         4'd3: return m_ir;
         4'd4: return m_dr;
         4'd5: return m_r[rs];
         4'd6: return m_ac;
         4'd7: return dr_in;
         4'd8: return ir_in;
         default: return '0;
      endcase
   endfunction

   task automatic model_step(input logic rst, input logic [3:0] bs, input logic [5:0] l,
                             input logic [1:0] rs, input logic inc, input logic [2:0] op,
                             input logic start, input logic [W-1:0] dr_in, input logic [W-1:0] ir_in);
      logic [W-1:0] b, res;
      logic [W:0]   wide;
      exp_t         e;
      b = model_bus(bs, rs, dr_in, ir_in);
      if (rst) begin
         m_ar = '0; m_pc = '0; m_dr = '0; m_ir = '0; m_ac = '0;
         for (int i = 0; i < 4; i++) m_r[i] = '0;
         m_z = 0; m_n = 0; m_c = 0; m_mul_left = 0; m_mul_prod = '0;
      end else begin
         if (l[0]) m_r[rs] = b;
         if (l[1]) m_ar = b;
         if (l[2]) m_dr = b;
         if (l[5]) m_ir = b;
         if (l[4]) m_pc = b;
         else if (inc) m_pc = m_pc + 1;
         if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
               m_ac = m_mul_prod[W-1:0];
               m_z  = (m_ac == 0);
               m_n  = m_ac[W-1];
               m_c  = (m_mul_prod[2*W-1:W] != 0);
            end
         end else if (start) begin
            if (op == 3'd7) begin
               m_mul_prod = {{W{1'b0}}, m_ac} * {{W{1'b0}}, b};
               m_mul_left = W;
            end else begin
               res = b;
               case (op)
                  3'd1: begin wide = {1'b0, m_ac} + {1'b0, b}; res = wide[W-1:0]; m_c = wide[W]; end
                  3'd2: begin res = m_ac - b; m_c = (m_ac < b); end
                  3'd3: begin res = m_ac & b; m_c = 0; end
                  3'd4: begin res = m_ac | b; m_c = 0; end
                  3'd5: begin res = m_ac ^ b; m_c = 0; end
                  3'd6: begin res = m_ac << 1; m_c = m_ac[W-1]; end
                  default: res = b;
               endcase
               m_ac = res;
               m_z  = (res == 0);
               m_n  = res[W-1];
            end
         end else if (l[3]) begin
            m_ac = b;
         end
      end
      e.pc = m_pc; e.ar = m_ar; e.ir = m_ir; e.ac = m_ac;
      e.z = m_z; e.n = m_n; e.c = m_c; e.busy = (m_mul_left > 0);
      exp_q.push_back(e);
   endtask

   // ---------------- driver ----------------
   // Applies inputs just after a falling edge, checks the combinational
   // bus, records the expected post-edge state, then waits one cycle.
   task automatic drive(input logic rst, input logic [3:0] bs, input logic [5:0] l,
                        input logic [1:0] rs, input logic inc, input logic [2:0] op,
                        input logic start, input logic [W-1:0] dr_in, input logic [W-1:0] ir_in);
      reset = rst; bus_sel = bs; ld = l; reg_sel = rs; pc_inc = inc;
      alu_op = op; alu_start = start; dram_in = dr_in; iram_in = ir_in;
      #1;
      check("bus_out", bus_out, model_bus(bs, rs, dr_in, ir_in));
      model_step(rst, bs, l, rs, inc, op, start, dr_in, ir_in);
      @(negedge clock);
   endtask

   task automatic idle();
      drive(0, 4'd0, 6'd0, 2'd0, 0, 3'd0, 0, '0, '0);
   endtask

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("pc_addr",  pc_addr,  mon_e.pc);
         check("addr_out", addr_out, mon_e.ar);
         check("ir_out",   ir_out,   mon_e.ir);
         check("ac_out",   ac_out,   mon_e.ac);
         check("flags",    {flag_z, flag_n, flag_c}, {mon_e.z, mon_e.n, mon_e.c});
         check("busy",     busy,     mon_e.busy);
      end
   end

   // ---------------- stimulus ----------------
   int busy_cnt;

   initial begin
      reset = 1; bus_sel = 0; ld = 0; reg_sel = 0; pc_inc = 0;
      alu_op = 0; alu_start = 0; dram_in = 0; iram_in = 0;
      @(negedge clock);

      // Reset state.
      drive(1, 4'd0, 6'd0, 2'd0, 0, 3'd0, 0, '0, '0);
      check("rst_pc", pc_addr, 16'h0);
      check("rst_ar", addr_out, 16'h0);
      check("rst_ir", ir_out, 16'h0);
      check("rst_ac", ac_out, 16'h0);
      check("rst_busy_flags", {busy, flag_z, flag_n, flag_c}, 4'b0000);
      check("rst_bus", bus_out, 16'h0);

      // Load AC from dram, DR, then ADD that wraps to zero.
      drive(0, 4'd7, 6'b001000, 2'd0, 0, 3'd0, 0, 16'h1234, '0);
      check("ld_ac", ac_out, 16'h1234);
      drive(0, 4'd7, 6'b000100, 2'd0, 0, 3'd0, 0, 16'hEDCC, '0);
      drive(0, 4'd4, 6'b000000, 2'd0, 0, 3'd1, 1, '0, '0);
      check("add_ac", ac_out, 16'h0000);
      check("add_znc", {flag_z, flag_n, flag_c}, 3'b101);

      // ALU priority over ld[3] in the same cycle.
      drive(0, 4'd7, 6'b001000, 2'd0, 0, 3'd4, 1, 16'h8001, '0);
      check("or_prio", ac_out, 16'h8001);

      // PC wrap, then load beats increment.
      drive(0, 4'd7, 6'b010000, 2'd0, 0, 3'd0, 0, 16'hFFFF, '0);
      drive(0, 4'd0, 6'b000000, 2'd0, 1, 3'd0, 0, '0, '0);
      check("pc_wrap", pc_addr, 16'h0000);
      drive(0, 4'd8, 6'b010000, 2'd0, 1, 3'd0, 0, '0, 16'h0100);
      check("pc_ld_win", pc_addr, 16'h0100);

      // Multiple loads in one cycle, register read shows pre-edge value.
      drive(0, 4'd8, 6'b100011, 2'd2, 0, 3'd0, 0, '0, 16'h0005);
      drive(0, 4'd5, 6'b000001, 2'd2, 0, 3'd0, 0, '0, '0);
      check("ir_multi", ir_out, 16'h0005);

      // MUL 3 * 5, busy exactly 16 cycles.
      drive(0, 4'd7, 6'b001000, 2'd0, 0, 3'd0, 0, 16'h0003, '0);
      drive(0, 4'd5, 6'b000000, 2'd2, 0, 3'd7, 1, '0, '0);
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         busy_cnt++;
         idle();
      end
      check("mul_busy_cycles", busy_cnt, 16);
      check("mul_ac", ac_out, 16'h000F);
      check("mul_c", flag_c, 1'b0);

      // MUL 0x100 * 0x100 with ignored ADD/ld[3] and a normal AR load.
      drive(0, 4'd7, 6'b001001, 2'd1, 0, 3'd0, 0, 16'h0100, '0);
      drive(0, 4'd5, 6'b000000, 2'd1, 0, 3'd7, 1, '0, '0);
      idle(); idle();
      drive(0, 4'd7, 6'b001010, 2'd0, 0, 3'd1, 1, 16'hBEEF, '0);
      check("busy_ar_ld", addr_out, 16'hBEEF);
      check("busy_ac_hold", ac_out, 16'h0100);
      for (int i = 0; i < 40 && busy; i++) idle();
      check("mul2_ac", ac_out, 16'h0000);
      check("mul2_zc", {flag_z, flag_c}, 2'b11);

      // Reset during the 5th busy cycle aborts the MUL.
      drive(0, 4'd7, 6'b001001, 2'd3, 0, 3'd0, 0, 16'h0007, '0);
      drive(0, 4'd5, 6'b000000, 2'd3, 0, 3'd7, 1, '0, '0);
      repeat (4) idle();
      drive(1, 4'd0, 6'd0, 2'd0, 0, 3'd0, 0, '0, '0);
      check("abort_busy", busy, 1'b0);
      check("abort_ac", ac_out, 16'h0);
      repeat (20) idle();
      check("abort_ac_late", ac_out, 16'h0);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)),
               6'($urandom), 2'($urandom), 1'($urandom), 3'($urandom),
               ($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom));
      end
      repeat (20) idle();

      @(negedge clock);
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so a stuck run still ends with a report.
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
